// File: rtl/fpadd_test_sequencer_pkg.sv
// Shared types, default parameters and the stored operand table for the FP adder test sequencer.
package fpadd_test_sequencer_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    localparam int NUM_DEFAULT     = 10;
    localparam int TIMEOUT_DEFAULT = 15;
    localparam int PTR_W           = 4;
    localparam int VEC_W           = 64;

    // Upper word is operand A, lower word is operand B.
    function automatic logic [VEC_W-1:0] test_vector(input logic [PTR_W-1:0] sel);
        logic [VEC_W-1:0] vec;
        case (sel)
            4'd0:    vec = 64'h3f800000_40000000;
            4'd1:    vec = 64'hbf800000_3f800000;
            4'd2:    vec = 64'hc2de8000_45155e00;
            4'd3:    vec = 64'h6b64b235_6ac49214;
            4'd4:    vec = 64'h2ac49214_6ac49214;
            4'd5:    vec = 64'hbfc66666_3fc7ae14;
            4'd6:    vec = 64'hc565ee8b_4565ee8a;
            4'd7:    vec = 64'h447a4efa_c47a1ccd;
            4'd8:    vec = 64'h00000000_00000000;
            4'd9:    vec = 64'h38108900_bb908900;
            default: vec = 64'h0;
        endcase
        return vec;
    endfunction

endpackage

// File: rtl/btn_pulse.sv
// Push-button conditioning: two-flop synchronizer, rising-edge detect, registered one-cycle pulse.
module btn_pulse (
    input  logic clk,
    input  logic rst,
    input  logic button,
    output logic pulse
);

    logic sync_1;
    logic sync_2;
    logic sync_prev;

    // The pulse is registered so it lands exactly three edges after the raw rise.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_1    <= 1'b0;
            sync_2    <= 1'b0;
            sync_prev <= 1'b0;
            pulse     <= 1'b0;
        end else begin
            sync_1    <= button;
            sync_2    <= sync_1;
            sync_prev <= sync_2;
            pulse     <= sync_2 & ~sync_prev;
        end
    end

endmodule

// File: rtl/fpadd_test_sequencer.sv
// Issues stored operand pairs to an FP adder one at a time, on a press or continuously under auto_run,
// and captures each result (or a timeout marker) for display.
//
// state   | meaning
// IDLE    | waiting for a press pulse or auto_run
// ISSUE   | op_valid high with vector[ptr] until the adder accepts
// WAIT    | counting cycles for res_valid, timeout at TIMEOUT-1
// HOLD    | one cycle: advance ptr, decide whether to continue
module fpadd_test_sequencer
    import fpadd_test_sequencer_pkg::*;
#(
    parameter int NUM     = NUM_DEFAULT,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        button,
    input  logic        auto_run,
    output logic [31:0] op_a,
    output logic [31:0] op_b,
    output logic        op_valid,
    input  logic        op_ready,
    input  logic        res_valid,
    input  logic [31:0] res_in,
    output logic [31:0] result,
    output logic [3:0]  idx,
    output logic        busy,
    output logic        err_timeout
);

    localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(NUM - 1);
    localparam logic [3:0]       TIMER_LAST = 4'(TIMEOUT - 1);

    state_t            state;
    state_t            state_nxt;
    logic [PTR_W-1:0]  ptr;
    logic [3:0]        timer;
    logic              press;
    logic              accept;
    logic              timer_done;
    logic              ptr_at_last;
    logic [VEC_W-1:0]  cur_vec;

    btn_pulse u_btn_pulse (
        .clk    (clk),
        .rst    (rst),
        .button (button),
        .pulse  (press)
    );

    assign accept      = (state == S_ISSUE) && op_ready;
    assign timer_done  = (timer == TIMER_LAST);
    assign ptr_at_last = (ptr == PTR_LAST);
    assign cur_vec     = test_vector(ptr);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Presses seen outside IDLE simply fall through: there is no pending-request flop.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (press || auto_run) begin
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (op_ready) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (res_valid || timer_done) begin
                    state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (auto_run && !ptr_at_last) begin
                    state_nxt = S_ISSUE;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
        endcase
    end

    // Operands come straight from ptr, which only moves in HOLD, so they are stable throughout ISSUE.
    always_comb begin
        op_valid = 1'b0;
        busy     = 1'b1;
        op_a     = cur_vec[63:32];
        op_b     = cur_vec[31:0];
        unique case (state)
            S_IDLE:  busy     = 1'b0;
            S_ISSUE: op_valid = 1'b1;
            S_WAIT:  ;
            S_HOLD:  ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr         <= '0;
            idx         <= '0;
            timer       <= '0;
            result      <= '0;
            err_timeout <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: ;
                S_ISSUE: begin
                    if (accept) begin
                        idx   <= ptr;
                        timer <= '0;
                    end
                end
                S_WAIT: begin
                    // A strobe on the final counted cycle still counts as a good result.
                    if (res_valid) begin
                        result      <= res_in;
                        err_timeout <= 1'b0;
                    end else if (timer_done) begin
                        result      <= 32'hFFFF_FFFF;
                        err_timeout <= 1'b1;
                    end else begin
                        timer <= timer + 4'd1;
                    end
                end
                S_HOLD: begin
                    ptr <= ptr_at_last ? '0 : ptr + 1'b1;
                end
            endcase
        end
    end

endmodule
